// File: rtl/i_fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, RVFI trace record and IF/ID payload.
// Also holds the reset PC and a helper that builds the trace record for a fetched word.
package i_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h4000_0060;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        rvfi_t       rvfi_d;
    } IF_ID_stage_t;

    // Only the PC pair is known at fetch; later stages fill in the rest.
    function automatic rvfi_t make_rvfi(input logic [31:0] pc);
        rvfi_t r;
        r          = '0;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 32'd4;
        return r;
    endfunction

endpackage

// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, issues I-memory reads and drives the IF/ID register.
// Handles ID back-pressure, EX redirects and discarding responses of squashed requests.
module i_fetch
    import i_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         imem_read_o,
    output logic [31:0]  imem_address_o,
    input  logic [31:0]  imem_rdata_i,
    input  logic         imem_resp_i,
    output IF_ID_stage_t if_out,
    output logic         if_valid_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  hold_ir_q, hold_ir_d;
    IF_ID_stage_t if_out_q, if_out_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        hold_ir_d  = hold_ir_q;
        if_out_d   = if_out_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            StFetch: begin
                if (imem_resp_i) begin
                    if (redirect_i) begin
                        pc_d       = redirect_pc_i;
                        if_valid_d = 1'b0;
                    end else if (!stall_i) begin
                        if_out_d.pc     = pc_q;
                        if_out_d.ir     = imem_rdata_i;
                        if_out_d.rvfi_d = make_rvfi(pc_q);
                        if_valid_d      = 1'b1;
                        pc_d            = pc_plus4;
                    end else begin
                        hold_ir_d = imem_rdata_i;
                        state_d   = StHold;
                    end
                end else begin
                    if (redirect_i) begin
                        // The in-flight request still owes a response; wait it out.
                        pend_pc_d  = redirect_pc_i;
                        if_valid_d = 1'b0;
                        state_d    = StDrain;
                    end else if (!stall_i) begin
                        if_valid_d = 1'b0;
                    end
                end
            end

            StHold: begin
                if (redirect_i) begin
                    pc_d       = redirect_pc_i;
                    if_valid_d = 1'b0;
                    state_d    = StFetch;
                end else if (!stall_i) begin
                    if_out_d.pc     = pc_q;
                    if_out_d.ir     = hold_ir_q;
                    if_out_d.rvfi_d = make_rvfi(pc_q);
                    if_valid_d      = 1'b1;
                    pc_d            = pc_plus4;
                    state_d         = StFetch;
                end
            end

            StDrain: begin
                if_valid_d = 1'b0;
                if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                end
                if (imem_resp_i) begin
                    pc_d    = redirect_i ? redirect_pc_i : pend_pc_q;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            hold_ir_q  <= '0;
            if_out_q   <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            hold_ir_q  <= hold_ir_d;
            if_out_q   <= if_out_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_read_o    = !rst && (state_q != StHold);
    assign imem_address_o = pc_q;
    assign if_out         = if_out_q;
    assign if_valid_o     = if_valid_q;

    redirect_aligned: assert property (@(posedge clk) disable iff (rst)
        redirect_i |-> (redirect_pc_i[1:0] == 2'b00));

endmodule

// File: tb/tb_i_fetch.sv
// Directed testbench for i_fetch: reset, streaming, stall/hold, redirect drain and PC wrap.
module tb_i_fetch;
    import i_fetch_pkg::*;

    logic         clk;
    logic         rst;
    logic         stall_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         imem_read_o;
    logic [31:0]  imem_address_o;
    logic [31:0]  imem_rdata_i;
    logic         imem_resp_i;
    IF_ID_stage_t if_out;
    logic         if_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    i_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_read_o   (imem_read_o),
        .imem_address_o(imem_address_o),
        .imem_rdata_i  (imem_rdata_i),
        .imem_resp_i   (imem_resp_i),
        .if_out        (if_out),
        .if_valid_o    (if_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rs, input logic [31:0] rdata);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_resp_i   = rs;
        imem_rdata_i  = rdata;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        check_eq("rst_read", {31'b0, imem_read_o}, 32'd0);
        check_eq("rst_valid", {31'b0, if_valid_o}, 32'd0);
        check_eq("rst_ifpc", if_out.pc, 32'h0);
        check_eq("rst_ifir", if_out.ir, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_read", {31'b0, imem_read_o}, 32'd1);
        check_eq("post_rst_addr", imem_address_o, 32'h4000_0060);

        // 1: response every second cycle, no stall
        tick();
        check_eq("t1_addr_hold", imem_address_o, 32'h4000_0060);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000);
        tick();
        check_eq("t1_valid0", {31'b0, if_valid_o}, 32'd1);
        check_eq("t1_pc0", if_out.pc, 32'h4000_0060);
        check_eq("t1_ir0", if_out.ir, 32'hA000_0000);
        check_eq("t1_rvfi_rd", if_out.rvfi_d.pc_rdata, 32'h4000_0060);
        check_eq("t1_rvfi_wd", if_out.rvfi_d.pc_wdata, 32'h4000_0064);
        check_eq("t1_rvfi_insn", if_out.rvfi_d.insn, 32'h0);
        check_eq("t1_addr1", imem_address_o, 32'h4000_0064);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_eq("t1_bubble", {31'b0, if_valid_o}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0001);
        tick();
        check_eq("t1_valid1", {31'b0, if_valid_o}, 32'd1);
        check_eq("t1_pc1", if_out.pc, 32'h4000_0064);
        check_eq("t1_addr2", imem_address_o, 32'h4000_0068);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        // 2: stall for three cycles across a response
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hA000_0002);
        tick();
        check_eq("t2_read_h0", {31'b0, imem_read_o}, 32'd0);
        check_eq("t2_pc_h0", if_out.pc, 32'h4000_0064);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_eq("t2_read_h1", {31'b0, imem_read_o}, 32'd0);
        tick();
        check_eq("t2_read_h2", {31'b0, imem_read_o}, 32'd0);
        check_eq("t2_ir_h2", if_out.ir, 32'hA000_0001);
        check_eq("t2_addr_h2", imem_address_o, 32'h4000_0068);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_eq("t2_rel_valid", {31'b0, if_valid_o}, 32'd1);
        check_eq("t2_rel_pc", if_out.pc, 32'h4000_0068);
        check_eq("t2_rel_ir", if_out.ir, 32'hA000_0002);
        check_eq("t2_rel_read", {31'b0, imem_read_o}, 32'd1);
        check_eq("t2_rel_addr", imem_address_o, 32'h4000_006C);
        tick();
        check_eq("t2_once", {31'b0, if_valid_o}, 32'd0);

        // 3: redirect with response outstanding -> drain, discard stale word
        drive(1'b0, 1'b1, 32'h4000_1000, 1'b0, 32'h0);
        tick();
        check_eq("t3_valid_d0", {31'b0, if_valid_o}, 32'd0);
        check_eq("t3_read_d0", {31'b0, imem_read_o}, 32'd1);
        check_eq("t3_addr_d0", imem_address_o, 32'h4000_006C);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_eq("t3_addr_d1", imem_address_o, 32'h4000_006C);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        tick();
        check_eq("t3_valid_stale", {31'b0, if_valid_o}, 32'd0);
        check_eq("t3_new_addr", imem_address_o, 32'h4000_1000);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0000);
        tick();
        check_eq("t3_tgt_valid", {31'b0, if_valid_o}, 32'd1);
        check_eq("t3_tgt_pc", if_out.pc, 32'h4000_1000);
        check_eq("t3_tgt_ir", if_out.ir, 32'hB000_0000);

        // 4: redirect coincident with response and stall
        drive(1'b1, 1'b1, 32'h4000_2000, 1'b1, 32'hC000_0000);
        tick();
        check_eq("t4_valid", {31'b0, if_valid_o}, 32'd0);
        check_eq("t4_addr", imem_address_o, 32'h4000_2000);
        check_eq("t4_read", {31'b0, imem_read_o}, 32'd1);

        // 5: two redirects while draining, latest wins
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        tick();
        check_eq("t5_addr_drain", imem_address_o, 32'h4000_2000);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0001);
        tick();
        check_eq("t5_addr", imem_address_o, 32'h0000_0200);
        check_eq("t5_valid", {31'b0, if_valid_o}, 32'd0);

        // 6: reset in the middle of a drain
        drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        check_eq("t6_read_rst", {31'b0, imem_read_o}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("t6_read", {31'b0, imem_read_o}, 32'd1);
        check_eq("t6_addr", imem_address_o, 32'h4000_0060);
        check_eq("t6_valid", {31'b0, if_valid_o}, 32'd0);
        tick();
        check_eq("t6_addr_idle", imem_address_o, 32'h4000_0060);

        // PC wraps modulo 2^32
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        tick();
        check_eq("wrap_tgt", imem_address_o, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hF000_000F);
        tick();
        check_eq("wrap_addr", imem_address_o, 32'h0000_0000);
        check_eq("wrap_pc", if_out.pc, 32'hFFFF_FFFC);
        check_eq("wrap_wdata", if_out.rvfi_d.pc_wdata, 32'h0000_0000);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
